// File: rtl/imem_loader.sv
// Boot loader: host word stream (hdr = count N, then N words) -> instruction memory writes, then cpu_enable.
// Latency: write on the port 1 cycle after each accepted word; cpu_enable 1 cycle after last write (N+2 with verify).
// Backpressure: s_ready only in HDR/LOAD; halt aborts from any state. Optional read-back: IMEM_LOADER_VERIFY_EN.
module imem_loader #(
    parameter int          MAX_WORDS = 128,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] loaded_words
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
`ifdef IMEM_LOADER_VERIFY_EN
        S_VERIFY,
`endif
        S_RUN,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] loaded_q, loaded_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wen_q, wen_d;
    logic        s_ready_q, s_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        en_q, en_d;
    logic        xfer;
    logic [63:0] idx_addr;

    // halt wins over a simultaneous handshake so an aborted load never writes
    assign xfer     = s_valid && s_ready_q && !halt;
    assign idx_addr = BASE_ADDR + {46'd0, idx_q, 2'b00};

`ifdef IMEM_LOADER_VERIFY_EN
    logic [31:0] csum_q, csum_d;
    logic [31:0] rsum_q, rsum_d;
    logic [15:0] scnt_q, scnt_d;
    logic        ren_q, ren_d;
    logic        rvld_q;
    logic [31:0] rsum_next;

    assign rsum_next = rsum_q + rdata_ext;
    assign ren_ext   = ren_q;

    // read-back bookkeeping: checksum, running read sum, sample pipeline flag
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            csum_q <= '0;
            rsum_q <= '0;
            scnt_q <= '0;
            ren_q  <= 1'b0;
            rvld_q <= 1'b0;
        end else begin
            csum_q <= csum_d;
            rsum_q <= rsum_d;
            scnt_q <= scnt_d;
            ren_q  <= ren_d;
            rvld_q <= ren_q;
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^rdata_ext;
    assign ren_ext      = 1'b0;
`endif

    // state and registered outputs
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            idx_q     <= '0;
            loaded_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            loaded_q  <= loaded_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            en_q      <= en_d;
        end
    end

    // next-state, port values and flags decoded from the next state
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        idx_d    = idx_q;
        loaded_d = loaded_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wen_d    = 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
        csum_d   = csum_q;
        rsum_d   = rsum_q;
        scnt_d   = scnt_q;
        ren_d    = 1'b0;
`endif
        if (halt) begin
            state_d  = S_IDLE;
            loaded_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_HDR;
                        loaded_d = '0;
                        idx_d    = '0;
`ifdef IMEM_LOADER_VERIFY_EN
                        csum_d   = '0;
`endif
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        n_d = s_data[15:0];
                        if (s_data[15:0] == 16'd0 || s_data[15:0] > 16'(MAX_WORDS)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        wen_d    = 1'b1;
                        addr_d   = idx_addr;
                        wdata_d  = s_data;
                        loaded_d = loaded_q + 16'd1;
                        idx_d    = idx_q + 16'd1;
`ifdef IMEM_LOADER_VERIFY_EN
                        csum_d   = csum_q + s_data;
`endif
                        if (idx_q == n_q - 16'd1) begin
                            idx_d   = '0;
`ifdef IMEM_LOADER_VERIFY_EN
                            state_d = S_VERIFY;
                            rsum_d  = '0;
                            scnt_d  = '0;
`else
                            state_d = S_RUN;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_VERIFY_EN
                S_VERIFY: begin
                    // first read issues at the edge that ends the last write cycle
                    if (idx_q != n_q) begin
                        ren_d  = 1'b1;
                        addr_d = idx_addr;
                        idx_d  = idx_q + 16'd1;
                    end
                    if (rvld_q) begin
                        rsum_d = rsum_next;
                        scnt_d = scnt_q + 16'd1;
                        if (scnt_q == n_q - 16'd1) begin
                            state_d = (rsum_next == csum_q) ? S_RUN : S_ERR;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
        s_ready_d = (state_d == S_HDR) || (state_d == S_LOAD);
`ifdef IMEM_LOADER_VERIFY_EN
        busy_d    = s_ready_d || (state_d == S_VERIFY);
`else
        busy_d    = s_ready_d;
`endif
        error_d   = (state_d == S_ERR);
        // enable waits for the final write pulse to leave the port
        en_d      = (state_d == S_RUN) && !wen_d;
        done_d    = en_d;
    end

    assign s_ready      = s_ready_q;
    assign addr_ext     = addr_q;
    assign wen_ext      = wen_q;
    assign wdata_ext    = wdata_q;
    assign cpu_enable   = en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign loaded_words = loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed host streams, write scoreboard checked by a negedge monitor.
// A small memory model answers reads one cycle after ren_ext and can corrupt one chosen read.
// Flag/timing checks run from the stimulus process after each rising edge.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext = '0;
    logic        cpu_enable;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] loaded_words;

    imem_loader dut (
        .clk(clk), .arst_n(arst_n), .start(start), .halt(halt),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error),
        .loaded_words(loaded_words)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          last_gap = 0;
    int          wr_count = 0;
    int          rd_n = 0;
    int          corrupt_at = -1;
    logic [31:0] mem [0:127];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // instruction memory model with a one-cycle read
    always @(posedge clk) begin
        if (wen_ext) mem[addr_ext[8:2]] <= wdata_ext;
        if (ren_ext) begin
            rdata_ext <= mem[addr_ext[8:2]] + ((rd_n == corrupt_at) ? 32'd1 : 32'd0);
            rd_n      <= rd_n + 1;
        end
    end

    // write monitor: every write must match the next scoreboard entry
    always @(negedge clk) begin
        if (wen_ext) begin
            wr_t e;
            wr_count++;
            last_gap    = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
            chk("wen_ren_exclusive", {63'd0, ren_ext}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", addr_ext, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", addr_ext, e.a);
                chk("write_data", {32'd0, wdata_ext}, {32'd0, e.d});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
    endtask

    // present a word and return just after the edge that accepts it
    task automatic send_word(input logic [31:0] w);
        bit ok = 0;
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 50; i++) begin
            if (s_ready) begin
                tick();
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_load_word(input int k, input logic [31:0] w);
        wr_t e;
        e.a = 64'(k) * 64'd4;
        e.d = w;
        exp_q.push_back(e);
        send_word(w);
    endtask

    // called in the last-write cycle; returns cycles until cpu_enable rises
    task automatic wait_enable(output int n);
        n = 0;
        while (!cpu_enable && !error && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic check_idle_flags(input string tag);
        chk({tag, "_s_ready"}, {63'd0, s_ready}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_error"}, {63'd0, error}, 64'd0);
        chk({tag, "_cpu_enable"}, {63'd0, cpu_enable}, 64'd0);
    endtask

    initial begin
        logic [31:0] prog [0:3];
        int          n;
        prog[0] = 32'h0000_0013;
        prog[1] = 32'h0010_0093;
        prog[2] = 32'h0020_8113;
        prog[3] = 32'h0030_0193;

        // reset state
        #12;
        check_idle_flags("rst");
        chk("rst_addr", addr_ext, 64'd0);
        chk("rst_wen", {63'd0, wen_ext}, 64'd0);
        chk("rst_loaded", {48'd0, loaded_words}, 64'd0);
        arst_n = 1'b1;
        tick();

        // basic back-to-back load of 3 words
        pulse_start();
        chk("hdr_s_ready", {63'd0, s_ready}, 64'd1);
        chk("hdr_busy", {63'd0, busy}, 64'd1);
        send_word(32'hABCD_0003);
        for (int k = 0; k < 3; k++) send_load_word(k, prog[k]);
        s_valid = 1'b0;
        chk("basic_loaded", {48'd0, loaded_words}, 64'd3);
        chk("basic_s_ready_dropped", {63'd0, s_ready}, 64'd0);
        chk("basic_enable_not_yet", {63'd0, cpu_enable}, 64'd0);
        wait_enable(n);
`ifdef IMEM_LOADER_VERIFY_EN
        chk("basic_enable_delay", 64'(n), 64'd5);
`else
        chk("basic_enable_delay", 64'(n), 64'd1);
`endif
        chk("basic_gap", 64'(last_gap), 64'd1);
        chk("basic_done", {63'd0, done}, 64'd1);
        pulse_start();
        chk("run_ignores_start", {63'd0, s_ready}, 64'd0);
        chk("run_still_done", {63'd0, done}, 64'd1);
        do_halt();
        check_idle_flags("run_halt");
        chk("run_halt_loaded", {48'd0, loaded_words}, 64'd0);

        // header bounds
        pulse_start();
        send_word(32'h0000_0000);
        s_valid = 1'b0;
        chk("hdr0_error", {63'd0, error}, 64'd1);
        chk("hdr0_no_ready", {63'd0, s_ready}, 64'd0);
        tick();
        chk("hdr0_no_wen", {63'd0, wen_ext}, 64'd0);
        do_halt();
        check_idle_flags("hdr0_halt");
        pulse_start();
        send_word(32'h0000_0081);
        s_valid = 1'b0;
        chk("hdr129_error", {63'd0, error}, 64'd1);
        do_halt();
        check_idle_flags("hdr129_halt");

        // gapped stream, 2 words
        wr_count = 0;
        pulse_start();
        send_word(32'h0000_0002);
        send_load_word(0, 32'h1111_2222);
        s_valid = 1'b0;
        s_data  = 32'hDEAD_BEEF;
        tick();
        chk("gap_no_wen", {63'd0, wen_ext}, 64'd0);
        chk("gap_loaded", {48'd0, loaded_words}, 64'd1);
        send_load_word(1, 32'h3333_4444);
        s_valid = 1'b0;
        wait_enable(n);
        chk("gap_enabled", {63'd0, cpu_enable}, 64'd1);
        chk("gap_write_count", 64'(wr_count), 64'd2);
        do_halt();

        // abort after the second word of four, then reload from base
        pulse_start();
        send_word(32'h0000_0004);
        send_load_word(0, prog[0]);
        send_load_word(1, prog[1]);
        s_valid = 1'b0;
        do_halt();
        check_idle_flags("abort");
        chk("abort_loaded", {48'd0, loaded_words}, 64'd0);
        tick();
        tick();
        chk("abort_enable_low", {63'd0, cpu_enable}, 64'd0);
        pulse_start();
        send_word(32'h0000_0001);
        send_load_word(0, 32'h0000_0073);
        s_valid = 1'b0;
        wait_enable(n);
        chk("reload_enabled", {63'd0, cpu_enable}, 64'd1);
        chk("reload_loaded", {48'd0, loaded_words}, 64'd1);
        do_halt();

`ifdef IMEM_LOADER_VERIFY_EN
        // corrupted third read-back -> error
        corrupt_at = rd_n + 2;
        pulse_start();
        send_word(32'h0000_0004);
        for (int k = 0; k < 4; k++) send_load_word(k, prog[k]);
        s_valid = 1'b0;
        wait_enable(n);
        chk("verify_bad_error", {63'd0, error}, 64'd1);
        chk("verify_bad_enable", {63'd0, cpu_enable}, 64'd0);
        do_halt();
        corrupt_at = -1;
        pulse_start();
        send_word(32'h0000_0004);
        for (int k = 0; k < 4; k++) send_load_word(k, prog[k]);
        s_valid = 1'b0;
        wait_enable(n);
        chk("verify_ok_delay", 64'(n), 64'd6);
        chk("verify_ok_done", {63'd0, done}, 64'd1);
        do_halt();
`endif

        // asynchronous reset in the middle of LOAD
        pulse_start();
        send_word(32'h0000_0003);
        send_load_word(0, 32'h5555_AAAA);
        s_valid = 1'b0;
        @(negedge clk);
        #1 arst_n = 1'b0;
        #1;
        check_idle_flags("midrst");
        chk("midrst_wen", {63'd0, wen_ext}, 64'd0);
        chk("midrst_addr", addr_ext, 64'd0);
        chk("midrst_loaded", {48'd0, loaded_words}, 64'd0);
        #1 arst_n = 1'b1;
        tick();
        pulse_start();
        chk("midrst_restart_ready", {63'd0, s_ready}, 64'd1);
        chk("midrst_restart_busy", {63'd0, busy}, 64'd1);
        do_halt();
        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that sits directly upstream of the `cpu` top. It accepts a word stream from a host with a valid/ready handshake, writes it into instruction memory through the CPU's external port (`addr_ext`/`wen_ext`/`wdata_ext`) and can optionally read it back to verify it. When the image is loaded it drives the CPU's `enable`. It replaces ad-hoc testbench pokes of the external memory port with one deterministic boot sequence.

## Interface
Parameters:
- `MAX_WORDS`, default 128: largest accepted image in words (512 B instruction memory / 4).
- `BASE_ADDR`, default 64'h0: byte address of the first instruction word.

Ports:
- `clk`  in  1  system clock, all logic rising-edge.
- `arst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE.
- `halt`  in  1  abort or stop; returns the block to IDLE from any state. Has priority over `start`.
- `s_valid`  in  1  host word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  32  host word.
- `addr_ext`  out  64  instruction-memory byte address; connects to `cpu.addr_ext`.
- `wen_ext`  out  1  instruction-memory write enable.
- `ren_ext`  out  1  instruction-memory read enable.
- `wdata_ext`  out  32  write word.
- `rdata_ext`  in  32  read word, valid the cycle after `ren_ext`.
- `cpu_enable`  out  1  connects to `cpu.enable`.
- `busy`  out  1  high in HDR, LOAD and VERIFY.
- `done`  out  1  high in RUN.
- `error`  out  1  high in ERR.
- `loaded_words`  out  16  number of words written so far.

## Operation
- States: IDLE, HDR, LOAD, VERIFY (macro only), RUN, ERR. All outputs are registered.
- A word transfers when `s_valid && s_ready` at a rising edge. `s_ready` is high only in HDR and LOAD.
- **IDLE:** on `start`, go to HDR. Clear `loaded_words`, the index and the checksum.
- **HDR:** the first word transfer sets N = `s_data[15:0]`.
  - If N == 0 or N > `MAX_WORDS`, go to ERR.
  - Otherwise go to LOAD.
  - `s_data[31:16]` is ignored.
- **LOAD:** for word transfer k (0-based):
  - Next cycle: `wen_ext`=1, `addr_ext`=`BASE_ADDR`+4k, `wdata_ext`=word.
  - `loaded_words` increments at the same edge.
  - A 32-bit checksum accumulates sum mod 2^32 of the words.
  - Back-to-back transfers give one write per cycle.
  - When transfer N−1 is accepted, `s_ready` drops at the same edge and the state leaves LOAD.
- **RUN:** `cpu_enable`=1 and `done`=1, held until `halt`. `start` is ignored.
- **ERR:** `error`=1, held until `halt`.
- **halt:** takes effect at the next edge and moves to IDLE. It clears `cpu_enable`, `ren_ext`, `s_ready` and the flags. A `wen_ext` pulse already on the port in that cycle completes.
- Busy-state rules:
  - `start` while not in IDLE is ignored.
  - `s_valid` with `s_ready`=0 is ignored; data is not consumed.
- Address arithmetic is 64-bit unsigned. The index never exceeds `MAX_WORDS`−1, so there is no wrap.

## Timing
- Reset values: state IDLE; every output 0; `addr_ext`=0; `loaded_words`=0. Reset mid-load abandons the load, and memory contents are left as written.
- Last write to `cpu_enable`, without the macro: `cpu_enable` rises the cycle after the last `wen_ext` pulse, i.e. 2 cycles after the last transfer.
- `wen_ext` and `ren_ext` are never high in the same cycle.
- With the macro: VERIFY starts the cycle after the last `wen_ext`. Reads issue one per cycle (`ren_ext`=1 for N consecutive cycles, addresses `BASE_ADDR`+4k). Each `rdata_ext` is sampled one cycle after its read. Compare happens after the final sample, and the result is RUN or ERR on the following edge. That is N+2 cycles after the last write.

## Configuration
- `IMEM_LOADER_VERIFY_EN` defined:
  - VERIFY state is present.
  - The read-back sum is compared against the load checksum.
  - A mismatch goes to ERR; a match goes to RUN.
- Not defined:
  - VERIFY is removed and `ren_ext` is tied 0.
  - LOAD goes directly to RUN.
  - The checksum logic may be removed.

## Test plan
- **Basic load:** header 3, words 0x00000013, 0x00100093, 0x00208113 with `s_valid` held → writes at addresses 0, 4, 8 on consecutive cycles, `loaded_words`=3, then `cpu_enable`=1 and `done`=1.
- **Header bounds:** header 0 → `error`=1 with no `wen_ext`. Header 129 with `MAX_WORDS`=128 → `error`=1. Then `halt` → all flags 0.
- **Gapped stream:** header 2 with `s_valid` toggling every other cycle → exactly 2 writes at addresses 0 and 4, data matching, and no extra write while `s_valid`=0.
- **Abort:** `halt` after word 1 of 4 → IDLE, `cpu_enable` stays 0, `loaded_words` cleared. A new `start` then reloads from `BASE_ADDR`.
- **Verify with macro:** after 4 words, force `rdata_ext`+1 on the third read → `error`=1. Unforced run → `cpu_enable` rises N+2 = 6 cycles after the last write.
- **Reset mid-LOAD:** assert `arst_n`=0 → all outputs 0 immediately. Release, then `start` → block back in HDR with `s_ready`=1.
